// File: rtl/song_reader.sv
// song_reader: walks through one of four songs stored in song_rom.
// For each note it fetches {note, duration} and hands it to the downstream
// note player. It then waits for that note to finish before fetching the next.
//
// state | meaning
// IDLE  | after reset, waiting for play
// FETCH | ROM address presented, data arrives next cycle
// ISSUE | ROM data valid; pulse new_note, or detect the end marker
// WAIT  | note loaded, waiting for note_done
// END   | song finished, holding until a different song is selected

module song_rom #(
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   output logic [11:0]       dout
);

   // Fixed song table, {note[5:0], duration[5:0]}; duration 0 marks end of song.
   function automatic logic [11:0] rom_word(input logic [1:0] s, input logic [4:0] i);
      logic [5:0] i6;
      i6 = {1'b0, i};
      rom_word = 12'd0;
      case (s)
         2'd0:    if (i < 5'd3) rom_word = {i6 + 6'd1, i6 + 6'd2};
         2'd1:    rom_word = {i6 + 6'd12, i6 + 6'd10};
         2'd2:    rom_word = {i6 + 6'd32, 6'd1 + {4'd0, i[1:0]}};
         default: if (i < 5'd16) rom_word = {6'd63 - i6, 6'd3};
      endcase
   endfunction

   // Synchronous read; the output only moves when enabled so it stays stable between fetches.
   always_ff @(posedge clk) begin
      if (en) dout <= rom_word(addr[ADDR_W-1 -: 2], addr[4:0]);
   end

endmodule

module song_reader #(
   parameter int NOTES_PER_SONG = 32,
   parameter int ADDR_W         = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       play,
   input  logic [1:0] song,
   input  logic       note_done,
   output logic [5:0] note,
   output logic [5:0] duration,
   output logic       new_note,
   output logic       song_done
);

   typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, END} state_t;

   localparam logic [4:0] LAST_INDEX = 5'(NOTES_PER_SONG - 1);

   state_t            state, state_d;
   logic [4:0]        note_index, index_d;
   logic [1:0]        song_q;
   logic              done_q;
   logic              song_change;
   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [11:0]       rom_dout;

   assign rom_addr    = ADDR_W'({song_q, note_index});
   assign rom_en      = (state == FETCH);
   assign song_change = play && (song != song_q);
   assign note        = rom_dout[11:6];
   assign duration    = rom_dout[5:0];
   // done_q is only ever set while playing, but a pause still silences it
   assign song_done   = done_q && play;

   song_rom #(.ADDR_W(ADDR_W)) u_rom (
      .clk  (clk),
      .en   (rom_en),
      .addr (rom_addr),
      .dout (rom_dout)
   );

   // State, index and registered song select; song_done is a one-cycle flag set on END entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         note_index <= 5'd0;
         song_q     <= 2'd0;
         done_q     <= 1'b0;
      end else begin
         state      <= state_d;
         note_index <= index_d;
         if (play) song_q <= song;
         done_q     <= (state_d == END) && (state != END);
      end
   end

   // Next-state and new_note decode; with play low everything holds and no pulses are produced.
   always_comb begin
      state_d  = state;
      index_d  = note_index;
      new_note = 1'b0;
      if (play) begin
         if (song_change) begin
            // a different song wins over any other event, including a pending new_note
            state_d = FETCH;
            index_d = 5'd0;
         end else begin
            case (state)
               IDLE: begin
                  state_d = FETCH;
                  index_d = 5'd0;
               end
               FETCH: state_d = ISSUE;
               ISSUE: begin
                  if (duration != 6'd0) begin
                     new_note = 1'b1;
                     state_d  = WAIT;
                  end else begin
                     state_d = END;
                     index_d = 5'd0;
                  end
               end
               WAIT: begin
                  if (note_done) begin
                     if (note_index == LAST_INDEX) begin
                        state_d = END;
                        index_d = 5'd0;
                     end else begin
                        state_d = FETCH;
                        index_d = note_index + 5'd1;
                     end
                  end
               end
               END:     index_d = 5'd0;
               default: state_d = IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader: a per-cycle vector table followed by
// hand-written sequences for a full song, a collision and an asynchronous reset.

module tb_song_reader;

   logic       clk = 1'b0;
   logic       reset;
   logic       play;
   logic [1:0] song;
   logic       note_done;
   logic [5:0] note;
   logic [5:0] duration;
   logic       new_note;
   logic       song_done;

   int n_cmp = 0;
   int n_bad = 0;
   int nn_count = 0;
   logic prev_nn = 1'b0;

   typedef struct {
      logic       p;
      logic [1:0] s;
      logic       nd;
      logic       nn;
      logic       sd;
      logic       cn;
      logic [5:0] n;
      logic [5:0] d;
   } vec_t;

   vec_t tbl [34];

   song_reader dut (
      .clk       (clk),
      .reset     (reset),
      .play      (play),
      .song      (song),
      .note_done (note_done),
      .note      (note),
      .duration  (duration),
      .new_note  (new_note),
      .song_done (song_done)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Apply inputs for one cycle, compare outputs mid-cycle, then advance past the next edge.
   task automatic step(input logic p, input logic [1:0] s, input logic nd,
                       input logic enn, input logic esd, input logic cn,
                       input logic [5:0] en, input logic [5:0] ed, input string tag);
      play = p; song = s; note_done = nd;
      #1;
      chk({tag, " new_note"}, {11'd0, new_note}, {11'd0, enn});
      chk({tag, " song_done"}, {11'd0, song_done}, {11'd0, esd});
      chk({tag, " new_note back-to-back"}, {11'd0, new_note & prev_nn}, 12'd0);
      if (cn) begin
         chk({tag, " note"}, {6'd0, note}, {6'd0, en});
         chk({tag, " duration"}, {6'd0, duration}, {6'd0, ed});
      end
      if (new_note === 1'b1) nn_count++;
      prev_nn = new_note;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t v(input logic p, input logic [1:0] s, input logic nd,
                              input logic nn, input logic sd, input logic cn,
                              input logic [5:0] n, input logic [5:0] d);
      vec_t r;
      r.p = p; r.s = s; r.nd = nd; r.nn = nn; r.sd = sd; r.cn = cn; r.n = n; r.d = d;
      return r;
   endfunction

   initial begin
      int base;
      logic [5:0] en, ed;

      // start on song 1, advance, pause in WAIT
      tbl[0]  = v(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0);
      tbl[1]  = v(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0);
      tbl[2]  = v(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 6'd12, 6'd10);
      tbl[3]  = v(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd12, 6'd10);
      tbl[4]  = v(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd12, 6'd10);
      tbl[5]  = v(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd12, 6'd10);
      tbl[6]  = v(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 6'd13, 6'd11);
      tbl[7]  = v(1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd13, 6'd11);
      tbl[8]  = v(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 6'd13, 6'd11);
      tbl[9]  = v(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd13, 6'd11);
      tbl[10] = v(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd13, 6'd11);
      tbl[11] = v(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd13, 6'd11);
      tbl[12] = v(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd13, 6'd11);
      tbl[13] = v(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 6'd14, 6'd12);
      // switch to song 0 mid-WAIT, play up to the end marker at index 3
      tbl[14] = v(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd14, 6'd12);
      tbl[15] = v(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd14, 6'd12);
      tbl[16] = v(1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd1,  6'd2);
      tbl[17] = v(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd1,  6'd2);
      tbl[18] = v(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1,  6'd2);
      tbl[19] = v(1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd2,  6'd3);
      tbl[20] = v(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd2,  6'd3);
      tbl[21] = v(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2,  6'd3);
      tbl[22] = v(1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd3,  6'd4);
      tbl[23] = v(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd3,  6'd4);
      tbl[24] = v(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd3,  6'd4);
      tbl[25] = v(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0,  6'd0);
      tbl[26] = v(1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0,  6'd0);
      tbl[27] = v(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0,  6'd0);
      tbl[28] = v(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0,  6'd0);
      // leave END for song 2, then change to song 3 right in ISSUE: pulse suppressed
      tbl[29] = v(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0,  6'd0);
      tbl[30] = v(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0,  6'd0);
      tbl[31] = v(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 6'd32, 6'd1);
      tbl[32] = v(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 6'd32, 6'd1);
      tbl[33] = v(1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 6'd63, 6'd3);

      reset = 1'b1; play = 1'b0; song = 2'd0; note_done = 1'b0;
      #2;
      chk("reset new_note", {11'd0, new_note}, 12'd0);
      chk("reset song_done", {11'd0, song_done}, 12'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, "idle hold");

      for (int i = 0; i < 34; i++) begin
         step(tbl[i].p, tbl[i].s, tbl[i].nd, tbl[i].nn, tbl[i].sd, tbl[i].cn,
              tbl[i].n, tbl[i].d, $sformatf("vec%0d", i));
      end

      // full song 2: 32 notes, END after the last note_done, no wrap
      base = nn_count;
      step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, "full start");
      for (int k = 0; k < 32; k++) begin
         en = 6'(32 + k);
         ed = 6'(1 + (k % 4));
         step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, $sformatf("full fetch%0d", k));
         step(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, en, ed, $sformatf("full issue%0d", k));
         step(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, en, ed, $sformatf("full wait%0d", k));
      end
      step(1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, "full song_done");
      for (int k = 0; k < 3; k++)
         step(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, "full end hold");
      chk("full pulse count", 12'(nn_count - base), 12'd32);

      // collision: reset, run song 2 to index 5, then song change with note_done
      reset = 1'b1; play = 1'b0;
      prev_nn = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, "col start");
      for (int k = 0; k < 5; k++) begin
         en = 6'(32 + k);
         ed = 6'(1 + (k % 4));
         step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, "col fetch");
         step(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, en, ed, "col issue");
         step(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, en, ed, "col wait");
      end
      step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0, "col fetch5");
      step(1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 6'd37, 6'd2, "col issue5 nd");
      step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 6'd37, 6'd2, "col wait5");
      step(1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 6'd37, 6'd2, "col change");
      step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0, "col fetch s3");
      step(1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 6'd63, 6'd3, "col issue s3");
      step(1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 6'd63, 6'd3, "col wait s3");
      step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0, "col fetch s3i1");

      // asynchronous reset while new_note is high: output drops without a clock edge
      play = 1'b1; song = 2'd3; note_done = 1'b0;
      #1;
      chk("pre-reset new_note", {11'd0, new_note}, 12'd1);
      chk("pre-reset note", {6'd0, note}, 12'd62);
      reset = 1'b1;
      #1;
      chk("async reset new_note", {11'd0, new_note}, 12'd0);
      chk("async reset song_done", {11'd0, song_done}, 12'd0);
      prev_nn = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0, "post-reset idle");
      step(1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0, "post-reset idle nd");
      step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0, "restart");
      step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  6'd0, "restart fetch");
      step(1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 6'd63, 6'd3, "restart issue idx0");
      step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 6'd63, 6'd3, "restart wait");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/song_reader.md
SONG_READER -- requirements
Module: song_reader

Interface
REQ-001 Parameter NOTES_PER_SONG, default 32, notes per song slot; the last index is NOTES_PER_SONG-1.
REQ-002 Parameter ADDR_W, default 7, song_rom address width: {song[1:0], note_index[4:0]}.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-high.
REQ-005 play  input  1  high = advance through the song, low = freeze all state.
REQ-006 song  input  2  selects one of 4 songs.
REQ-007 note_done  input  1  pulse from the downstream note_player (done_with_note): current note finished.
REQ-008 note  output  6  note number to load (note_to_load).
REQ-009 duration  output  6  duration in 1/48 s beats (duration_to_load).
REQ-010 new_note  output  1  single-cycle pulse: note/duration valid, load them (load_new_note).
REQ-011 song_done  output  1  single-cycle pulse: current song finished.

Function
REQ-012 The block shall instantiate song_rom: synchronous read, 1-cycle latency, dout[11:0] = {note[5:0], duration[5:0]}; note/duration shall be driven directly from dout.
REQ-013 The FSM shall have states IDLE, FETCH, ISSUE, WAIT and END, and a 5-bit note_index.
REQ-014 IDLE: when play=1, go to FETCH with note_index=0.
REQ-015 FETCH: the ROM address is {song_q, note_index}; go to ISSUE unconditionally after 1 cycle (ROM latency).
REQ-016 ISSUE, duration!=0: new_note=1 for exactly this cycle, then go to WAIT.
REQ-017 ISSUE, duration==0: treat as end-of-song marker; new_note stays 0, go to END.
REQ-018 WAIT, note_done=1 and note_index<NOTES_PER_SONG-1: increment note_index and go to FETCH.
REQ-019 WAIT, note_done=1 and note_index==NOTES_PER_SONG-1: go to END; note_index does not wrap.
REQ-020 song_done shall be a registered pulse, high exactly the first cycle the FSM is in END.
REQ-021 END: hold, with note_index reset to 0, until a song change (REQ-023).
REQ-022 play=0: the FSM, note_index and song_q shall hold; new_note=0 and song_done=0 regardless of state; note_done is ignored.
REQ-023 Song change, from any state while play=1: song_q is the registered song and is updated every such cycle; when song != song_q, force note_index=0 and go to FETCH.
  - This has priority over every other transition, including a simultaneous note_done.
  - A pending new_note in that cycle is suppressed.
REQ-024 Latency: from the cycle the FSM enters FETCH to the new_note pulse is exactly 1 cycle (FETCH, ISSUE): the pulse is in the 2nd cycle counting FETCH.
  - Consequence: from IDLE with play rising, new_note is high 2 cycles after play is first sampled.
REQ-025 note/duration shall stay stable from ISSUE through WAIT, because the address changes only on FETCH entry.
REQ-026 While new_note=1, note_done is ignored (the note is not yet loaded).
REQ-027 A new_note pulse requires a FETCH first, so new_note shall never be high in two consecutive cycles.

Reset
REQ-028 Asserting reset at any time shall immediately set:
  - state=IDLE, note_index=0, song_q=0
  - new_note=0, song_done=0
  - note/duration are don't-care until the first ISSUE.
REQ-029 On release, the block shall start in IDLE; a mid-song reset discards progress, and the next play starts at note_index 0 of the current song.

Verification
REQ-030 Scenario, normal start: reset, song=1, ROM[1,0]={12,10}, play=1 -> new_note pulses 1 cycle, 2 cycles after play is sampled; note=12, duration=10.
REQ-031 Scenario, advance: note_done pulse in WAIT -> note_index 0->1; new_note pulses again 2 cycles later; note/duration = ROM[1,1].
REQ-032 Scenario, end marker: ROM[0,3] duration=0 -> after the note_done for index 2, no new_note; song_done pulses exactly 1 cycle; the FSM stays in END with no further pulses.
REQ-033 Scenario, full song: all 32 durations nonzero -> 32 new_note pulses; song_done follows the 32nd note_done; note_index never wraps to 0 silently.
REQ-034 Scenario, pause: play=0 during WAIT with note_done pulsed -> no index change, no new_note; play=1 -> still WAIT until the next note_done.
REQ-035 Scenario, collision: song change 2->3 in the same cycle as note_done at index 5 -> the next new_note carries ROM[3,0]; asynchronous reset mid-WAIT -> outputs 0 in the same cycle and IDLE on release.
